// File: rtl/machine_run_controller.sv
// Run/step/halt/dump sequencer for the single-cycle MIPS core.
// Optional breakpoint support is compiled in with RUN_CTRL_BREAKPOINT_EN.
module machine_run_controller #(
  parameter int CNT_W  = 32,
  parameter int NREGS  = 32,
  parameter int DATA_W = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [CNT_W-1:0]  cmd_arg,
  output logic              core_en,
  input  logic              core_except,
  input  logic [DATA_W-1:0] core_pc,
  output logic [4:0]        reg_sel,
  input  logic [DATA_W-1:0] reg_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [4:0]        dump_idx,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_last,
  output logic              halted,
  output logic [1:0]        halt_cause,
  output logic [CNT_W-1:0]  cycle_count,
`ifdef RUN_CTRL_BREAKPOINT_EN
  input  logic              bp_en,
  input  logic [DATA_W-1:0] bp_addr,
`endif
  output logic [2:0]        dbg_state
);

  // Handshakes: a command transfers on a rising edge with cmd_valid & cmd_ready;
  // a dump beat transfers with dump_valid & dump_ready, and dump_valid/idx/data
  // hold steady until that happens.

  localparam int IDX_W = 5;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREGS - 1);

  localparam logic [2:0] OP_RUN   = 3'd1;
  localparam logic [2:0] OP_STEP  = 3'd2;
  localparam logic [2:0] OP_HALT  = 3'd3;
  localparam logic [2:0] OP_DUMP  = 3'd4;
  localparam logic [2:0] OP_CLEAR = 3'd5;

  localparam logic [1:0] CAUSE_NONE   = 2'd0;
  localparam logic [1:0] CAUSE_BUDGET = 2'd1;
  localparam logic [1:0] CAUSE_EXCEPT = 2'd2;
  localparam logic [1:0] CAUSE_HOST   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_STEP   = 3'd2,
    S_HALTED = 3'd3,
    S_DUMP   = 3'd4
  } state_t;

  state_t              state_q, state_nxt;
  state_t              ret_q, ret_nxt;
  logic [CNT_W-1:0]    budget_q, budget_nxt;
  logic [1:0]          cause_q, cause_nxt;
  logic [IDX_W-1:0]    idx_q, idx_nxt;
  logic                dvalid_q, dvalid_nxt;
  logic [DATA_W-1:0]   data_q, data_nxt;
  logic [CNT_W-1:0]    cycle_q;
  logic                clr_cnt;
  logic                executing;
  logic                bp_hit;
  logic                en;
  logic                fire;

`ifdef RUN_CTRL_BREAKPOINT_EN
  // Set on RUN/STEP entry so the core can leave a PC that sits on the breakpoint.
  logic                skip_q, skip_nxt;
`else
  logic                unused_core_pc;
  assign unused_core_pc = ^core_pc;
`endif

  assign executing = (state_q == S_RUN) || (state_q == S_STEP);
`ifdef RUN_CTRL_BREAKPOINT_EN
  assign bp_hit = executing && bp_en && (core_pc == bp_addr) && !skip_q;
`else
  assign bp_hit = 1'b0;
`endif
  assign en        = executing && !bp_hit;
  assign cmd_ready = (state_q != S_DUMP);
  assign fire      = cmd_valid && cmd_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      ret_q    <= S_IDLE;
      budget_q <= '0;
      cause_q  <= CAUSE_NONE;
      idx_q    <= '0;
      dvalid_q <= 1'b0;
      data_q   <= '0;
`ifdef RUN_CTRL_BREAKPOINT_EN
      skip_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_nxt;
      ret_q    <= ret_nxt;
      budget_q <= budget_nxt;
      cause_q  <= cause_nxt;
      idx_q    <= idx_nxt;
      dvalid_q <= dvalid_nxt;
      data_q   <= data_nxt;
`ifdef RUN_CTRL_BREAKPOINT_EN
      skip_q   <= skip_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt  = state_q;
    ret_nxt    = ret_q;
    budget_nxt = budget_q;
    cause_nxt  = cause_q;
    idx_nxt    = idx_q;
    dvalid_nxt = dvalid_q;
    data_nxt   = data_q;
    clr_cnt    = 1'b0;
`ifdef RUN_CTRL_BREAKPOINT_EN
    skip_nxt   = skip_q;
`endif
    case (state_q)
      S_IDLE, S_HALTED: begin
        if (fire) begin
          case (cmd_op)
            OP_RUN: begin
              state_nxt  = S_RUN;
              budget_nxt = cmd_arg;
              cause_nxt  = CAUSE_NONE;
`ifdef RUN_CTRL_BREAKPOINT_EN
              skip_nxt   = 1'b1;
`endif
            end
            OP_STEP: begin
              state_nxt  = S_STEP;
              budget_nxt = (cmd_arg == '0) ? CNT_W'(1) : cmd_arg;
              cause_nxt  = CAUSE_NONE;
`ifdef RUN_CTRL_BREAKPOINT_EN
              skip_nxt   = 1'b1;
`endif
            end
            OP_DUMP: begin
              state_nxt  = S_DUMP;
              ret_nxt    = state_q;
              idx_nxt    = '0;
              dvalid_nxt = 1'b0;
            end
            OP_CLEAR: begin
              state_nxt = S_IDLE;
              cause_nxt = CAUSE_NONE;
              clr_cnt   = 1'b1;
            end
            default: ;
          endcase
        end
      end
      S_RUN, S_STEP: begin
`ifdef RUN_CTRL_BREAKPOINT_EN
        skip_nxt = 1'b0;
`endif
        // Host HALT outranks a breakpoint, an exception and budget expiry.
        if (fire && cmd_op == OP_HALT) begin
          state_nxt = S_HALTED;
          cause_nxt = CAUSE_HOST;
        end else if (bp_hit) begin
          state_nxt = S_HALTED;
          cause_nxt = CAUSE_HOST;
        end else if (core_except) begin
          state_nxt = S_HALTED;
          cause_nxt = CAUSE_EXCEPT;
        end else if (budget_q != '0) begin
          budget_nxt = budget_q - CNT_W'(1);
          if (budget_q == CNT_W'(1)) begin
            state_nxt = S_HALTED;
            cause_nxt = CAUSE_BUDGET;
          end
        end
      end
      S_DUMP: begin
        // One fetch cycle per beat: capture reg_data, then hold until taken.
        if (!dvalid_q) begin
          data_nxt   = reg_data;
          dvalid_nxt = 1'b1;
        end else if (dump_ready) begin
          dvalid_nxt = 1'b0;
          if (idx_q == LAST_IDX) begin
            idx_nxt   = '0;
            state_nxt = ret_q;
          end else begin
            idx_nxt = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycle_q <= '0;
    end else if (clr_cnt) begin
      cycle_q <= '0;
    end else if (en && (cycle_q != '1)) begin
      cycle_q <= cycle_q + CNT_W'(1);
    end
  end

  assign core_en     = en;
  assign reg_sel     = idx_q;
  assign dump_idx    = idx_q;
  assign dump_valid  = dvalid_q;
  assign dump_data   = data_q;
  assign dump_last   = dvalid_q && (idx_q == LAST_IDX);
  assign halted      = (state_q == S_HALTED);
  assign halt_cause  = cause_q;
  assign cycle_count = cycle_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_machine_run_controller.sv
// Randomized bench for machine_run_controller: run/step/halt sequencing and
// register dump, checked against a behavioural model of the run rules.
module tb_machine_run_controller;

  localparam int CNT_W  = 32;
  localparam int NREGS  = 32;
  localparam int DATA_W = 64;
  localparam int BEAT_W = 1 + 5 + DATA_W;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_RUN   = 3'd1;
  localparam logic [2:0] OP_STEP  = 3'd2;
  localparam logic [2:0] OP_HALT  = 3'd3;
  localparam logic [2:0] OP_DUMP  = 3'd4;
  localparam logic [2:0] OP_CLEAR = 3'd5;

  logic              clock;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [CNT_W-1:0]  cmd_arg;
  logic              core_en;
  logic              core_except;
  logic [DATA_W-1:0] core_pc;
  logic [4:0]        reg_sel;
  logic [DATA_W-1:0] reg_data;
  logic              dump_valid;
  logic              dump_ready;
  logic [4:0]        dump_idx;
  logic [DATA_W-1:0] dump_data;
  logic              dump_last;
  logic              halted;
  logic [1:0]        halt_cause;
  logic [CNT_W-1:0]  cycle_count;
  logic [2:0]        dbg_state;
`ifdef RUN_CTRL_BREAKPOINT_EN
  logic              bp_en;
  logic [DATA_W-1:0] bp_addr;
`endif

  logic              pc_clr;
  logic [DATA_W-1:0] regfile [NREGS];
  logic [BEAT_W-1:0] exp_q[$];
  longint            exp_cc;
  int                n_checks;
  int                n_pass;

  machine_run_controller #(.CNT_W(CNT_W), .NREGS(NREGS), .DATA_W(DATA_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_arg     (cmd_arg),
    .core_en     (core_en),
    .core_except (core_except),
    .core_pc     (core_pc),
    .reg_sel     (reg_sel),
    .reg_data    (reg_data),
    .dump_valid  (dump_valid),
    .dump_ready  (dump_ready),
    .dump_idx    (dump_idx),
    .dump_data   (dump_data),
    .dump_last   (dump_last),
    .halted      (halted),
    .halt_cause  (halt_cause),
    .cycle_count (cycle_count),
`ifdef RUN_CTRL_BREAKPOINT_EN
    .bp_en       (bp_en),
    .bp_addr     (bp_addr),
`endif
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset / core model ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Core stand-in: PC advances one instruction per enabled cycle.
  always @(posedge clock or negedge reset) begin
    if (!reset) core_pc <= '0;
    else if (pc_clr) core_pc <= '0;
    else if (core_en) core_pc <= core_pc + 64'd4;
  end

  assign reg_data = regfile[reg_sel];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [BEAT_W-1:0] got, input logic [BEAT_W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- drivers ----------------
  // Called at a negedge; returns at the negedge after the command edge.
  task automatic send_cmd(input logic [2:0] op, input logic [CNT_W-1:0] arg);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    @(posedge clock);
    @(negedge clock);
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
    cmd_arg   = '0;
  endtask

  // Counts enabled cycles until halted; raises core_except on enabled cycle exc_at.
  task automatic run_phase(input int exc_at, output int n_en, output int n_cyc);
    n_en  = 0;
    n_cyc = 0;
    while (!halted && n_cyc < 3000) begin
      if (core_en) begin
        n_en++;
        core_except = (n_en == exc_at);
      end else begin
        core_except = 1'b0;
      end
      @(negedge clock);
      n_cyc++;
    end
    core_except = 1'b0;
    check("run_timeout", BEAT_W'(n_cyc < 3000), BEAT_W'(1));
  endtask

  // Reference: budget limits the run, an exception on enabled cycle k stops it at k.
  task automatic do_run(input logic [2:0] op, input logic [CNT_W-1:0] arg, input int exc_at);
    int lim, exp_n, n_en, n_cyc;
    logic [1:0] exp_cause;
    lim = (op == OP_STEP && arg == 0) ? 1 : int'(arg);
    if (exc_at != 0 && (lim == 0 || exc_at <= lim)) begin
      exp_n = exc_at;
      exp_cause = 2'd2;
    end else begin
      exp_n = lim;
      exp_cause = 2'd1;
    end
    exp_cc += exp_n;
    check("pre_core_en", BEAT_W'(core_en), BEAT_W'(0));
    send_cmd(op, arg);
    check("en_latency", BEAT_W'(core_en), BEAT_W'(1));
    run_phase(exc_at, n_en, n_cyc);
    check("en_cycles", BEAT_W'(n_en), BEAT_W'(exp_n));
    check("en_contiguous", BEAT_W'(n_cyc), BEAT_W'(exp_n));
    check("halted", BEAT_W'(halted), BEAT_W'(1));
    check("halt_cause", BEAT_W'(halt_cause), BEAT_W'(exp_cause));
    check("en_off", BEAT_W'(core_en), BEAT_W'(0));
    check("cycle_count", BEAT_W'(cycle_count), BEAT_W'(exp_cc));
  endtask

  task automatic do_clear();
    send_cmd(OP_CLEAR, '0);
    exp_cc = 0;
  endtask

  // Dump with scoreboard; toggle=1 drives ready 1,0,1,... else random.
  // abort_at >= 0 asserts reset asynchronously once that beat index is valid.
  task automatic do_dump(input bit toggle, input int abort_at);
    logic [BEAT_W-1:0] beat, prev_beat;
    bit prev_stall, ph, done;
    bit rdy_bad, stall_bad, last_bad;
    int cyc;
    exp_q.delete();
    for (int i = 0; i < NREGS; i++)
      exp_q.push_back({(i == NREGS - 1), 5'(i), regfile[i]});
    send_cmd(OP_DUMP, '0);
    prev_stall = 1'b0; ph = 1'b1; done = 1'b0;
    rdy_bad = 1'b0; stall_bad = 1'b0; last_bad = 1'b0;
    prev_beat = '0;
    cyc = 0;
    while (!done && exp_q.size() != 0 && cyc < 500) begin
      dump_ready = toggle ? ph : 1'($urandom_range(0, 1));
      ph = ~ph;
      beat = {dump_last, dump_idx, dump_data};
      if (cmd_ready !== 1'b0) rdy_bad = 1'b1;
      if (dump_last && !(dump_valid && dump_idx == 5'(NREGS - 1))) last_bad = 1'b1;
      if (prev_stall && (!dump_valid || beat !== prev_beat)) stall_bad = 1'b1;
      if (abort_at >= 0 && dump_valid && dump_idx == 5'(abort_at)) begin
        #2 reset = 1'b0;
        #1;
        check("rst_dump_valid", BEAT_W'(dump_valid), BEAT_W'(0));
        check("rst_dump_idx", BEAT_W'(dump_idx), BEAT_W'(0));
        check("rst_reg_sel", BEAT_W'(reg_sel), BEAT_W'(0));
        check("rst_dump_last", BEAT_W'(dump_last), BEAT_W'(0));
        check("rst_halted", BEAT_W'(halted), BEAT_W'(0));
        check("rst_halt_cause", BEAT_W'(halt_cause), BEAT_W'(0));
        check("rst_cycle_count", BEAT_W'(cycle_count), BEAT_W'(0));
        check("rst_core_en", BEAT_W'(core_en), BEAT_W'(0));
        check("rst_cmd_ready", BEAT_W'(cmd_ready), BEAT_W'(1));
        exp_q.delete();
        exp_cc = 0;
        dump_ready = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        done = 1'b1;
      end else begin
        if (dump_valid && dump_ready) check("dump_beat", beat, exp_q.pop_front());
        prev_stall = dump_valid && !dump_ready;
        prev_beat  = beat;
        @(negedge clock);
        cyc++;
      end
    end
    dump_ready = 1'b0;
    if (abort_at < 0) begin
      check("dump_complete", BEAT_W'(exp_q.size()), BEAT_W'(0));
      check("dump_cmd_ready_low", BEAT_W'(rdy_bad), BEAT_W'(0));
      check("dump_stall_hold", BEAT_W'(stall_bad), BEAT_W'(0));
      check("dump_last_only", BEAT_W'(last_bad), BEAT_W'(0));
      check("dump_valid_after", BEAT_W'(dump_valid), BEAT_W'(0));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n_en, n_cyc;
    logic [2:0] op;
    logic [CNT_W-1:0] arg;
    int exc;
    n_checks = 0; n_pass = 0; exp_cc = 0;
    reset = 1'b0; cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_arg = '0;
    core_except = 1'b0; dump_ready = 1'b0; pc_clr = 1'b0;
`ifdef RUN_CTRL_BREAKPOINT_EN
    bp_en = 1'b0; bp_addr = '0;
`endif
    for (int i = 0; i < NREGS; i++) regfile[i] = {$urandom, $urandom};

    #3;
    check("reset_state", BEAT_W'(dbg_state), BEAT_W'(0));
    check("reset_core_en", BEAT_W'(core_en), BEAT_W'(0));
    check("reset_dump_valid", BEAT_W'(dump_valid), BEAT_W'(0));
    check("reset_halted", BEAT_W'(halted), BEAT_W'(0));
    check("reset_cycle_count", BEAT_W'(cycle_count), BEAT_W'(0));
    check("reset_cmd_ready", BEAT_W'(cmd_ready), BEAT_W'(1));
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // Directed runs from the test plan.
    do_run(OP_RUN, 10, 0);
    do_clear();
    check("clear_cycle_count", BEAT_W'(cycle_count), BEAT_W'(0));
    check("clear_halt_cause", BEAT_W'(halt_cause), BEAT_W'(0));
    check("clear_halted", BEAT_W'(halted), BEAT_W'(0));
    do_run(OP_RUN, 0, 7);
    do_clear();
    do_run(OP_STEP, 0, 0);
    do_run(OP_STEP, 3, 0);

    // Randomized RUN/STEP mix against the model.
    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        op  = OP_RUN;
        arg = CNT_W'($urandom_range(0, 20));
        exc = (arg == 0) ? $urandom_range(1, 20) : $urandom_range(0, 25);
      end else begin
        op  = OP_STEP;
        arg = CNT_W'($urandom_range(0, 6));
        exc = $urandom_range(0, 8);
      end
      do_run(op, arg, exc);
    end

    // NOP and an undefined op in HALTED change nothing.
    send_cmd(OP_NOP, CNT_W'($urandom));
    send_cmd(3'd6, CNT_W'($urandom));
    send_cmd(3'd7, CNT_W'($urandom));
    check("nop_halted", BEAT_W'(halted), BEAT_W'(1));
    check("nop_core_en", BEAT_W'(core_en), BEAT_W'(0));
    check("nop_cycle_count", BEAT_W'(cycle_count), BEAT_W'(exp_cc));

    // Host HALT during RUN: DUMP/CLEAR ignored while running, HALT beats except.
    send_cmd(OP_RUN, '0);
    repeat (2) @(negedge clock);
    send_cmd(OP_DUMP, '0);
    check("run_dump_ignored", BEAT_W'({dump_valid, core_en}), BEAT_W'(2'b01));
    send_cmd(OP_CLEAR, '0);
    check("run_clear_ignored", BEAT_W'(core_en), BEAT_W'(1));
    core_except = 1'b1;
    send_cmd(OP_HALT, '0);
    core_except = 1'b0;
    exp_cc += 5;
    check("host_halted", BEAT_W'(halted), BEAT_W'(1));
    check("host_cause", BEAT_W'(halt_cause), BEAT_W'(3));
    check("host_core_en", BEAT_W'(core_en), BEAT_W'(0));
    check("host_cycle_count", BEAT_W'(cycle_count), BEAT_W'(exp_cc));

    // Dump from HALTED with a recognisable register pattern.
    for (int i = 0; i < NREGS; i++) regfile[i] = 64'(i) * 64'h1111;
    do_dump(1'b1, -1);
    check("dump_ret_halted", BEAT_W'(halted), BEAT_W'(1));
    check("dump_keep_cause", BEAT_W'(halt_cause), BEAT_W'(3));
    check("dump_idx_zero", BEAT_W'(dump_idx), BEAT_W'(0));

    // Random register contents, reset mid-dump, then a fresh dump from IDLE.
    for (int i = 0; i < NREGS; i++) regfile[i] = {$urandom, $urandom};
    do_dump(1'b0, 12);
    do_dump(1'b0, -1);
    check("dump_ret_idle", BEAT_W'(dbg_state), BEAT_W'(0));
    check("dump_idle_halted", BEAT_W'(halted), BEAT_W'(0));

    // Run after the dump still follows the budget rule.
    do_run(OP_RUN, CNT_W'($urandom_range(1, 15)), 0);

`ifdef RUN_CTRL_BREAKPOINT_EN
    do_clear();
    pc_clr = 1'b1;
    @(negedge clock);
    pc_clr = 1'b0;
    bp_en = 1'b1;
    bp_addr = 64'h40;
    send_cmd(OP_RUN, '0);
    run_phase(0, n_en, n_cyc);
    check("bp_en_cycles", BEAT_W'(n_en), BEAT_W'(16));
    check("bp_pc", BEAT_W'(core_pc), BEAT_W'(64'h40));
    check("bp_cause", BEAT_W'(halt_cause), BEAT_W'(3));
    check("bp_cycle_count", BEAT_W'(cycle_count), BEAT_W'(16));
    send_cmd(OP_RUN, 1);
    run_phase(0, n_en, n_cyc);
    check("bp_leave_cycles", BEAT_W'(n_en), BEAT_W'(1));
    check("bp_leave_pc", BEAT_W'(core_pc), BEAT_W'(64'h44));
    check("bp_leave_cause", BEAT_W'(halt_cause), BEAT_W'(1));
    check("bp_leave_count", BEAT_W'(cycle_count), BEAT_W'(17));
    bp_en = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/machine_run_controller.md
Name: machine_run_controller

Overview:
- Sequences the single-cycle 64-bit MIPS core for bench and debug use: run, single-step, halt and register dump.
- Gates the core's clock enable and enforces a cycle budget.
- Halts when the core raises an exception, then streams all 32 architectural registers out over a valid/ready handshake.
- Sits between the host/bench command interface and the core's except and debug register-read ports.

Parameters:
- CNT_W, 32, width of the cycle budget and cycle counters
- NREGS, 32, number of registers streamed by DUMP (index width 5)
- DATA_W, 64, register and PC width

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command strobe
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_op  in  3  0=NOP 1=RUN 2=STEP 3=HALT 4=DUMP 5=CLEAR; others ignored
- cmd_arg  in  CNT_W  RUN: cycle budget (0 = unlimited); STEP: step count (0 treated as 1)
- core_en  out  1  core clock enable; core commits one instruction per enabled cycle
- core_except  in  1  core exception flag
- core_pc  in  DATA_W  current core PC
- reg_sel  out  5  register-file debug read index
- reg_data  in  DATA_W  combinational read of reg_sel
- dump_valid  out  1  dump beat valid
- dump_ready  in  1  consumer ready
- dump_idx  out  5  register index of the current beat
- dump_data  out  DATA_W  register value
- dump_last  out  1  asserted on beat index NREGS-1
- halted  out  1  controller is in HALTED
- halt_cause  out  2  0=none 1=budget 2=except 3=host/breakpoint
- cycle_count  out  CNT_W  enabled cycles since the last CLEAR; saturates at all-ones

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - state IDLE, core_en=0, dump_valid=0, dump_last=0
  - dump_idx=0, reg_sel=0, halted=0, halt_cause=0, cycle_count=0
  - internal budget counter = 0
- States are IDLE, RUN, STEP, HALTED, DUMP.
- cmd_ready=1 in IDLE, HALTED, RUN and STEP; cmd_ready=0 in DUMP.
- IDLE/HALTED + RUN:
  - go to RUN next cycle; load budget=cmd_arg.
  - Clear halt_cause and halted.
  - core_en=1 from the cycle after acceptance (1-cycle latency).
- IDLE/HALTED + STEP: go to STEP; load budget=max(cmd_arg,1); core_en=1 for exactly that many cycles, then HALTED with halt_cause=1.
- RUN with budget!=0: decrement once per enabled cycle. In the cycle budget reaches 0: core_en=0 next cycle, enter HALTED, halt_cause=1.
- RUN/STEP, core_except=1 sampled on an enabled cycle:
  - That cycle still counts.
  - Next cycle: core_en=0, enter HALTED, halt_cause=2.
  - Except has priority over budget expiry in the same cycle.
- RUN/STEP + HALT command: core_en drops next cycle, HALTED, halt_cause=3. Host HALT has priority over except and budget in the same cycle.
- DUMP from IDLE or HALTED only; ignored (accepted as no-op) in RUN/STEP.
  - reg_sel=dump_idx; dump_data=reg_data, registered so dump_data is stable while dump_valid.
  - Beat advances on dump_valid & dump_ready.
  - dump_valid, dump_data and dump_idx hold while dump_ready=0.
  - After the beat with dump_last completes, return to the state DUMP was entered from, and dump_idx returns to 0.
- CLEAR (IDLE/HALTED only): cycle_count=0, halt_cause=0, halted=0, state IDLE.
- Unknown ops and NOP are accepted and ignored.
- cycle_count increments on every core_en=1 cycle and saturates without wrapping.
- A reset asserted mid-RUN or mid-DUMP aborts immediately to reset values; no partial beat is reported.
- core_en is never 1 outside RUN/STEP.

Optional Feature:
- Macro: RUN_CTRL_BREAKPOINT_EN.
- When defined:
  - Adds inputs bp_en (1) and bp_addr (DATA_W).
  - In RUN/STEP, core_pc==bp_addr with bp_en=1 sets core_en=0 before that instruction executes (combinational gate that cycle).
  - Enters HALTED with halt_cause=3.
  - The next RUN/STEP ignores a match on the first enabled cycle so execution can leave the breakpoint.
- When undefined: the ports are absent and halt_cause=3 arises only from host HALT.

Test Plan:
- RUN cmd_arg=10, core_except=0 → core_en high exactly 10 cycles starting 1 cycle after acceptance; halted=1, halt_cause=1, cycle_count=10.
- RUN cmd_arg=0, core_except pulsed on the 7th enabled cycle → cycle_count=7, halt_cause=2, core_en=0 the following cycle.
- STEP cmd_arg=0, then STEP cmd_arg=3 → cycle_count=1 after the first, 4 after the second; halt_cause=1 after each.
- HALTED + DUMP with dump_ready toggling 1,0,1,… and reg_data=idx*0x1111 → 32 beats, indices 0..31 in order, data stable during stalls, dump_last only on idx 31, cmd_ready=0 throughout.
- Reset asserted asynchronously mid-DUMP at idx 12 → all outputs at reset values immediately; a fresh DUMP restarts at idx 0.
- With RUN_CTRL_BREAKPOINT_EN defined, bp_addr=0x40 and the PC stepping by 4 from 0x0 → halt with core_pc=0x40, cycle_count=16, halt_cause=3. A subsequent RUN cmd_arg=1 advances past 0x40.
